// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared definitions for the inter-stage pipeline registers.
//            - State encodings of the 2-entry skid stage (value == occupancy)
//            - Payload layouts/widths that the RV32 stages pass in as DW
// Revision : 1.0  initial parametrised handshake stage
// ============================================================================
package pipe_pkg;

    // Handshake stage states; the encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // IF/ID payload: fetched pc and raw instruction.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    // ID/EX payload: decoded operands plus control word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [15:0] ctrl;
    } id_ex_t;

    // EX/MEM payload: ALU result, store data, destination and control.
    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] st_data;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } ex_mem_t;

    // MEM/WB payload: writeback value and destination.
    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        wb_en;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : W-bit event counter, either saturating at all-ones (SAT=1) or
//            wrapping modulo 2^W (SAT=0).
// Ports    : clk - rising-edge clock
//            rst - synchronous active-high reset, clears the count
//            inc - count one event this cycle
//            q   - current count
// Revision : 1.0  initial version
// ============================================================================
module sat_counter #(
    parameter int W   = 16,
    parameter bit SAT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;
    logic         w_en;

    generate
        if (SAT) begin : g_sat
            // Stop advancing once every bit is set.
            assign w_en = inc & ~(&r_q);
        end else begin : g_wrap
            assign w_en = inc;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (w_en) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Valid/ready pipeline stage register with a 2-entry skid buffer,
//            synchronous flush and stall/transfer performance counters.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            flush             - squash all held entries
//            in_valid/in_ready/in_data    - upstream handshake and payload
//            out_valid/out_ready/out_data - downstream handshake and payload
//            occupancy         - entries held (0..2)
//            stall_cnt         - saturating count of back-pressured cycles
//            xfer_cnt          - wrapping count of output transfers
// Revision : 1.0  initial parametrised handshake stage
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int            DW       = 32,
    parameter int            CNT_W    = 16,
    parameter logic [DW-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic [1:0]    r_state;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;

    logic [1:0]    w_state_nxt;
    logic [DW-1:0] w_main_nxt;
    logic [DW-1:0] w_skid_nxt;
    logic          w_in_fire;
    logic          w_out_fire;

    // Handshake outputs decode the state register only, so out_ready never
    // reaches in_ready combinationally.
    assign out_valid  = (r_state != ST_EMPTY);
    assign in_ready   = (r_state != ST_FULL);
    assign out_data   = r_main;
    assign occupancy  = r_state;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= RST_DATA;
            r_skid  <= RST_DATA;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            // Payload registers keep stale contents; only the state empties.
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_nxt  = in_data;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        // Head leaves as the new payload arrives: full rate.
                        w_main_nxt = in_data;
                    end else if (w_in_fire) begin
                        w_skid_nxt  = in_data;
                        w_state_nxt = ST_FULL;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_main_nxt  = r_skid;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    sat_counter #(
        .W   (CNT_W),
        .SAT (1'b1)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid & ~out_ready),
        .q   (stall_cnt)
    );

    sat_counter #(
        .W   (CNT_W),
        .SAT (1'b0)
    ) u_xfer_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_out_fire),
        .q   (xfer_cnt)
    );

endmodule
`default_nettype wire
